// File: rtl/phy_tx_lane_striper_pkg.sv
// Shared constants for the TX lane striper: K28.5 idle symbol, lane-count limits, width helper.
// No logic; imported by the striper top and its lane serializer.
// Backpressure: n/a.
package phy_tx_lane_striper_pkg;

   localparam logic [7:0]  K28_5_SYM = 8'hBC;
   localparam int unsigned LANES_MIN = 1;
   localparam int unsigned LANES_MAX = 8;

   // Counter/pointer width that never collapses to zero bits.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/phy_tx_lane_striper_lane_serializer.sv
// One lane: holds a word and shifts it out MSB byte first, registered output.
// Latency: first byte appears one edge after load; K bytes back-to-back.
// Backpressure: free is high when idle or on the last byte; loads only when free.
module phy_tx_lane_striper_lane_serializer
   import phy_tx_lane_striper_pkg::*;
#(
   parameter int               DATA_W   = 32,
   parameter int               BYTE_W   = 8,
   parameter logic [BYTE_W-1:0] IDLE_SYM = BYTE_W'(K28_5_SYM)
) (
   input  logic              clk_4f,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_word,
   output logic              free,
   output logic              idle,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid
);

   localparam int               K     = DATA_W / BYTE_W;
   localparam int               CNT_W = clog2_min1(K);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(K - 1);

   logic              busy;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;

   assign free = !busy || (cnt == LAST);
   assign idle = !busy;

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         busy       <= 1'b0;
         cnt        <= '0;
         shreg      <= '0;
         byte_out   <= IDLE_SYM;
         byte_valid <= 1'b0;
      end else begin
         byte_valid <= busy;
         byte_out   <= busy ? shreg[DATA_W-1 -: BYTE_W] : IDLE_SYM;
         // A load on the last byte replaces the word with no idle gap.
         if (load) begin
            busy  <= 1'b1;
            cnt   <= '0;
            shreg <= load_word;
         end else if (busy) begin
            if (cnt == LAST) busy <= 1'b0;
            else             cnt  <= cnt + 1'b1;
            shreg <= shreg << BYTE_W;
         end
      end
   end

endmodule

// File: rtl/phy_tx_lane_striper.sv
// Buffers words in a small FIFO and stripes them round-robin over the active lanes.
// Latency: accept at edge t, dispatch at t+1, first byte after t+2, last after t+1+K.
// Backpressure: ready = !full; valid while not ready raises a one-cycle drop.
module phy_tx_lane_striper
   import phy_tx_lane_striper_pkg::*;
#(
   parameter int               DATA_W     = 32,
   parameter int               BYTE_W     = 8,
   parameter int               LANES      = 2,
   parameter int               FIFO_DEPTH = 4,
   parameter logic [BYTE_W-1:0] IDLE_SYM   = BYTE_W'(K28_5_SYM)
) (
   input  logic                         clk_4f,
   input  logic                         reset,
   input  logic [DATA_W-1:0]            data_input,
   input  logic                         valid,
   output logic                         ready,
   input  logic [$clog2(LANES+1)-1:0]   active_lanes,
   output logic [LANES*BYTE_W-1:0]      data_out,
   output logic [LANES-1:0]             valid_out,
   output logic                         drop
);

   localparam int               ACT_W   = $clog2(LANES + 1);
   localparam int               AW      = clog2_min1(FIFO_DEPTH);
   localparam int               PAD     = 2 ** ACT_W;
   localparam logic [ACT_W-1:0] LANES_A = ACT_W'(LANES);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              full, empty, push, pop, quiescent;
   logic [ACT_W-1:0]  act_q, ptr, act_req;
   logic [LANES-1:0]  lane_free, lane_idle, lane_load;
   logic [PAD-1:0]    free_pad;
   logic [DATA_W-1:0] head_word;

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign ready     = !full && !reset;
   assign push      = valid && ready;
   assign drop      = valid && !ready && !reset;
   // Zero-padded so ptr can index it at its natural width.
   assign free_pad  = PAD'(lane_free);
   assign pop       = !empty && free_pad[ptr];
   assign quiescent = empty && (&lane_idle);
   assign head_word = mem[rd_ptr];

   always_comb begin
      act_req = active_lanes;
      if (active_lanes == '0)          act_req = ACT_W'(1);
      else if (active_lanes > LANES_A) act_req = LANES_A;
   end

   always_ff @(posedge clk_4f) begin
      if (push) mem[wr_ptr] <= data_input;
   end

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ptr    <= '0;
         act_q  <= LANES_A;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Lane count only changes with nothing in flight, so ordering never breaks.
         if (pop)
            ptr <= (ptr == act_q - 1'b1) ? '0 : ptr + 1'b1;
         else if (quiescent && (act_req != act_q)) begin
            act_q <= act_req;
            ptr   <= '0;
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_load[i] = pop && (ptr == ACT_W'(i));

      phy_tx_lane_striper_lane_serializer #(
         .DATA_W   (DATA_W),
         .BYTE_W   (BYTE_W),
         .IDLE_SYM (IDLE_SYM)
      ) u_ser (
         .clk_4f     (clk_4f),
         .reset      (reset),
         .load       (lane_load[i]),
         .load_word  (head_word),
         .free       (lane_free[i]),
         .idle       (lane_idle[i]),
         .byte_out   (data_out[i*BYTE_W +: BYTE_W]),
         .byte_valid (valid_out[i])
      );
   end

endmodule

// File: tb/tb_phy_tx_lane_striper.sv
// Bench for phy_tx_lane_striper (default parameters: 2 lanes, 32-bit words, 4-deep FIFO).
module tb_phy_tx_lane_striper;

   localparam logic [7:0] IDLE = 8'hBC;

   logic        clk_4f = 1'b0;
   logic        reset;
   logic [31:0] data_input;
   logic        valid;
   logic        ready;
   logic [1:0]  active_lanes;
   logic [15:0] data_out;
   logic [1:0]  valid_out;
   logic        drop;

   always #5 clk_4f = ~clk_4f;

   phy_tx_lane_striper dut (
      .clk_4f       (clk_4f),
      .reset        (reset),
      .data_input   (data_input),
      .valid        (valid),
      .ready        (ready),
      .active_lanes (active_lanes),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .drop         (drop)
   );

   typedef struct {
      int act_in;
      int exp_act;
      int nwords;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int  act_model = 2, pend_act = 2, wn = 0;
   bit  mon_en = 0, gap_en = 0, acc_arm = 0;
   int  cyc = 0, first_acc = 0, gaps = 0, acc_cnt = 0, drop_cnt = 0;
   int  first_v [2];
   int  vcnt [2];
   bit  started [2];
   logic [7:0] mb, me;
   int  msz;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic void sb_push(input int lane, input logic [31:0] w);
      for (int j = 0; j < 4; j++) begin
         if (lane == 0) q0.push_back(w[31-8*j -: 8]);
         else           q1.push_back(w[31-8*j -: 8]);
      end
   endfunction

   // Scoreboard: accepted words enqueue their bytes on the predicted lane; lane outputs dequeue.
   always @(negedge clk_4f) begin
      if (mon_en) begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            mb  = data_out[i*8 +: 8];
            msz = (i == 0) ? q0.size() : q1.size();
            if (valid_out[i]) begin
               vcnt[i]++;
               if (!started[i]) begin
                  started[i] = 1'b1;
                  first_v[i] = cyc;
               end
               if (msz == 0) check($sformatf("lane%0d_unexpected_valid", i), valid_out[i], 1'b0);
               else begin
                  if (i == 0) me = q0.pop_front();
                  else        me = q1.pop_front();
                  check($sformatf("lane%0d_byte", i), mb, me);
               end
            end else begin
               check($sformatf("lane%0d_idle_sym", i), mb, IDLE);
               if (gap_en && started[i] && msz > 0) gaps++;
            end
         end
         check("drop_pulse", drop, valid && !ready);
         if (valid && ready) begin
            sb_push(wn % act_model, data_input);
            wn++;
            acc_cnt++;
            if (acc_arm) begin
               first_acc = cyc;
               acc_arm   = 1'b0;
            end
         end
         if (valid && !ready) drop_cnt++;
      end
   end

   task automatic push_word(input logic [31:0] w);
      valid      = 1'b1;
      data_input = w;
      @(posedge clk_4f);
      #1;
      valid      = 1'b0;
   endtask

   task automatic push_n(input int n);
      for (int k = 0; k < n; k++) push_word($urandom);
   endtask

   task automatic set_act(input int act_in, input int exp_act);
      active_lanes = act_in[1:0];
      pend_act     = exp_act;
   endtask

   // Wait for every expected byte, then let the DUT go quiescent and sample active_lanes.
   task automatic drain();
      int k;
      k = 0;
      while ((q0.size() + q1.size()) != 0 && k < 400) begin
         @(posedge clk_4f);
         k++;
      end
      check("drain_in_time", (k < 400), 1'b1);
      repeat (3) @(posedge clk_4f);
      #1;
      if (pend_act != act_model) begin
         act_model = pend_act;
         wn        = 0;
      end
      started[0] = 1'b0;
      started[1] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl [5];
      int a0, d0, v0, v1, s0;

      tbl[0] = '{act_in: 2, exp_act: 2, nwords: 3};
      tbl[1] = '{act_in: 1, exp_act: 1, nwords: 4};
      tbl[2] = '{act_in: 0, exp_act: 1, nwords: 2};
      tbl[3] = '{act_in: 3, exp_act: 2, nwords: 4};
      tbl[4] = '{act_in: 2, exp_act: 2, nwords: 3};
      vcnt[0] = 0; vcnt[1] = 0;
      started[0] = 1'b0; started[1] = 1'b0;

      // Reset held three edges.
      reset = 1'b1; valid = 1'b0; data_input = '0; active_lanes = 2'd2;
      repeat (2) @(posedge clk_4f);
      @(negedge clk_4f);
      check("ready_during_reset", ready, 1'b0);
      @(posedge clk_4f);
      #1 reset = 1'b0;
      @(negedge clk_4f);
      check("reset_ready", ready, 1'b1);
      check("reset_data_out", data_out, 16'hBCBC);
      check("reset_valid_out", valid_out, 2'b00);
      check("reset_drop", drop, 1'b0);
      @(posedge clk_4f);
      #1 mon_en = 1'b1;

      // Two words back to back: exact first-byte latency per lane.
      set_act(2, 2);
      drain();
      acc_arm = 1'b1;
      push_word(32'hAABBCCDD);
      push_word(32'h11223344);
      drain();
      check("lane0_first_byte_latency", first_v[0] - first_acc, 3);
      check("lane1_first_byte_latency", first_v[1] - first_acc, 4);

      // Eight words on consecutive cycles: no backpressure, no idle gaps.
      d0 = drop_cnt;
      gaps = 0;
      gap_en = 1'b1;
      push_n(8);
      drain();
      gap_en = 1'b0;
      check("stream_no_drop", drop_cnt - d0, 0);
      check("stream_no_gap", gaps, 0);

      // Lane-count vectors, including 0 and out-of-range requests.
      for (int t = 0; t < 5; t++) begin
         set_act(tbl[t].act_in, tbl[t].exp_act);
         drain();
         v0 = vcnt[0] + vcnt[1];
         push_n(tbl[t].nwords);
         drain();
         check($sformatf("vec%0d_bytes", t), vcnt[0] + vcnt[1] - v0, tbl[t].nwords * 4);
      end

      // Single lane, valid held ten cycles: FIFO fills and words drop.
      set_act(1, 1);
      drain();
      a0 = acc_cnt; d0 = drop_cnt; v1 = vcnt[1];
      valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         data_input = $urandom;
         @(posedge clk_4f);
         #1;
      end
      valid = 1'b0;
      check("fill_accepted", acc_cnt - a0, 6);
      check("fill_dropped", drop_cnt - d0, 4);
      drain();
      check("fill_lane1_idle", vcnt[1] - v1, 0);

      // Lane-count change while busy is deferred until quiescent.
      set_act(2, 2);
      drain();
      push_word($urandom);
      active_lanes = 2'd1;
      pend_act     = 1;
      push_n(3);
      drain();
      v0 = vcnt[0]; v1 = vcnt[1];
      push_n(2);
      drain();
      check("deferred_act_lane0", vcnt[0] - v0, 8);
      check("deferred_act_lane1", vcnt[1] - v1, 0);

      // Reset while lane0 is on byte 2 of its word.
      set_act(2, 2);
      drain();
      push_word(32'hA1B2C3D4);
      push_n(2);
      @(posedge clk_4f);
      @(posedge clk_4f);
      #6;
      check("pre_reset_lane0_byte2", {valid_out[0], data_out[7:0]}, {1'b1, 8'hC3});
      mon_en = 1'b0;
      reset  = 1'b1;
      @(posedge clk_4f);
      #1 reset = 1'b0;
      @(negedge clk_4f);
      check("abort_valid_out", valid_out, 2'b00);
      check("abort_data_out", data_out, 16'hBCBC);
      check("abort_ready", ready, 1'b1);
      check("abort_drop", drop, 1'b0);
      q0.delete();
      q1.delete();
      act_model = 2; wn = 0;
      started[0] = 1'b0; started[1] = 1'b0;
      @(posedge clk_4f);
      #1 mon_en = 1'b1;
      s0 = vcnt[0] + vcnt[1];
      repeat (12) @(posedge clk_4f);
      #1;
      check("abort_no_flush", vcnt[0] + vcnt[1] - s0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
